// File: rtl/alpha_reverse_buffer.sv
// alpha_reverse_buffer: captures one alpha vector per trellis step into a
// ping-pong bank pair and replays each completed block in reverse step order
// for the backward (beta/LLR) stage.
module alpha_reverse_buffer #(
    parameter int unsigned BITS    = 16,
    parameter int unsigned STATES  = 4,
    parameter int unsigned SYMBOLS = 10,
    localparam int unsigned IDX_W  = $clog2(SYMBOLS)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic             block_start,
    input  logic [BITS-1:0]  AlphaMetric [STATES],
    output logic             in_ready,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [BITS-1:0]  out_alpha [STATES],
    output logic [IDX_W-1:0] out_index,
    output logic             out_last,
    output logic             overflow
);

    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(SYMBOLS - 1);
    localparam logic [IDX_W-1:0] PENULT_IDX = IDX_W'(SYMBOLS - 2);

    typedef enum logic {
        RD_IDLE = 1'b0,
        RD_RUN  = 1'b1
    } rd_state_t;

    // Storage: two banks of SYMBOLS vectors
    logic [BITS-1:0]  r_mem [2][SYMBOLS][STATES];
    logic [1:0]       r_full;
    logic [1:0]       w_full_nxt;

    // Write side
    logic             r_wr_bank;
    logic [IDX_W-1:0] r_wr_cnt;
    logic             r_wr_active;
    logic             r_overflow;
    logic             w_in_ready;
    logic             w_wr_store;
    logic             w_wr_drop;
    logic             w_wr_done;
    logic [IDX_W-1:0] w_wr_idx;

    // Read side
    rd_state_t        r_state;
    rd_state_t        w_state_nxt;
    logic             r_rd_bank;
    logic             w_rd_bank_nxt;
    logic             w_rd_other;
    logic [IDX_W-1:0] r_rd_cnt;
    logic [IDX_W-1:0] w_rd_cnt_nxt;
    logic             w_rd_free;
    logic             r_out_valid;
    logic             w_out_valid_nxt;
    logic [IDX_W-1:0] r_out_index;
    logic [IDX_W-1:0] w_out_index_nxt;
    logic             r_out_last;
    logic             w_out_last_nxt;
    logic [BITS-1:0]  r_out_alpha [STATES];
    logic [BITS-1:0]  w_out_alpha_nxt [STATES];

    // Write bank is open whenever it does not hold an unread block
    assign w_in_ready = !r_full[r_wr_bank];
    assign w_rd_other = ~r_rd_bank;

    // Write acceptance decode: store, drop, and block completion
    always_comb begin
        w_wr_store = 1'b0;
        w_wr_drop  = 1'b0;
        w_wr_idx   = r_wr_cnt;
        if (in_valid) begin
            if (!w_in_ready) begin
                w_wr_drop = 1'b1;
            end else if (block_start) begin
                w_wr_store = 1'b1;
                w_wr_idx   = '0;
            end else if (r_wr_active) begin
                w_wr_store = 1'b1;
            end else begin
                w_wr_drop = 1'b1;
            end
        end
        w_wr_done = w_wr_store && (w_wr_idx == LAST_IDX);
    end

    // Vector storage; contents need no reset since full flags gate all reads
    always_ff @(posedge clk) begin
        if (w_wr_store) begin
            r_mem[r_wr_bank][w_wr_idx] <= AlphaMetric;
        end
    end

    // Write pointer, block tracking and sticky overflow
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_bank   <= 1'b0;
            r_wr_cnt    <= '0;
            r_wr_active <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_wr_drop) begin
                r_overflow <= 1'b1;
            end
            if (w_wr_store) begin
                if (w_wr_done) begin
                    r_wr_bank   <= ~r_wr_bank;
                    r_wr_cnt    <= '0;
                    r_wr_active <= 1'b0;
                end else begin
                    r_wr_cnt    <= w_wr_idx + IDX_W'(1);
                    r_wr_active <= 1'b1;
                end
            end
        end
    end

    // Full flags: write completion and read release never target the same bank
    always_comb begin
        w_full_nxt = r_full;
        if (w_rd_free) begin
            w_full_nxt[r_rd_bank] = 1'b0;
        end
        if (w_wr_done) begin
            w_full_nxt[r_wr_bank] = 1'b1;
        end
    end

    // Full flag register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_full <= '0;
        end else begin
            r_full <= w_full_nxt;
        end
    end

    // Read FSM next state and output load selection
    always_comb begin
        w_state_nxt     = r_state;
        w_rd_bank_nxt   = r_rd_bank;
        w_rd_cnt_nxt    = r_rd_cnt;
        w_rd_free       = 1'b0;
        w_out_valid_nxt = r_out_valid;
        w_out_index_nxt = r_out_index;
        w_out_last_nxt  = r_out_last;
        w_out_alpha_nxt = r_out_alpha;
        case (r_state)
            RD_IDLE: begin
                if (r_full[r_rd_bank]) begin
                    w_out_alpha_nxt = r_mem[r_rd_bank][LAST_IDX];
                    w_out_index_nxt = LAST_IDX;
                    w_out_last_nxt  = 1'b0;
                    w_out_valid_nxt = 1'b1;
                    w_rd_cnt_nxt    = PENULT_IDX;
                    w_state_nxt     = RD_RUN;
                end
            end
            RD_RUN: begin
                if (r_out_valid && out_ready) begin
                    if (r_out_last) begin
                        // Block drained: release bank, chain into the other if ready
                        w_rd_free     = 1'b1;
                        w_rd_bank_nxt = w_rd_other;
                        if (r_full[w_rd_other]) begin
                            w_out_alpha_nxt = r_mem[w_rd_other][LAST_IDX];
                            w_out_index_nxt = LAST_IDX;
                            w_out_last_nxt  = 1'b0;
                            w_rd_cnt_nxt    = PENULT_IDX;
                        end else begin
                            w_out_valid_nxt = 1'b0;
                            w_state_nxt     = RD_IDLE;
                        end
                    end else begin
                        w_out_alpha_nxt = r_mem[r_rd_bank][r_rd_cnt];
                        w_out_index_nxt = r_rd_cnt;
                        w_out_last_nxt  = (r_rd_cnt == '0);
                        w_rd_cnt_nxt    = r_rd_cnt - IDX_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = RD_IDLE;
            end
        endcase
    end

    // Read FSM state and registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= RD_IDLE;
            r_rd_bank   <= 1'b0;
            r_rd_cnt    <= '0;
            r_out_valid <= 1'b0;
            r_out_index <= '0;
            r_out_last  <= 1'b0;
            r_out_alpha <= '{default: '0};
        end else begin
            r_state     <= w_state_nxt;
            r_rd_bank   <= w_rd_bank_nxt;
            r_rd_cnt    <= w_rd_cnt_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_out_index <= w_out_index_nxt;
            r_out_last  <= w_out_last_nxt;
            r_out_alpha <= w_out_alpha_nxt;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_alpha = r_out_alpha;
    assign out_index = r_out_index;
    assign out_last  = r_out_last;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_alpha_reverse_buffer.sv
// Bench for alpha_reverse_buffer: directed vector table, hand-written corner
// sequences, and randomized traffic against a block-level queue model.
module tb_alpha_reverse_buffer;

    localparam int unsigned BITS    = 16;
    localparam int unsigned STATES  = 4;
    localparam int unsigned SYMBOLS = 10;

    typedef logic [BITS*STATES-1:0] pvec_t;
    typedef struct {
        pvec_t v;
        int    idx;
    } exp_t;
    typedef struct {
        bit iv;
        bit bs;
        bit orr;
        int base;
        bit e_valid;
        int e_idx;
        bit e_last;
    } vec_rec_t;

    logic            clk;
    logic            reset_n;
    logic            in_valid;
    logic            block_start;
    logic [BITS-1:0] AlphaMetric [STATES];
    logic            in_ready;
    logic            out_ready;
    logic            out_valid;
    logic [BITS-1:0] out_alpha [STATES];
    logic [3:0]      out_index;
    logic            out_last;
    logic            overflow;

    int checks = 0;
    int errors = 0;

    // Reference model: completed blocks become a reversed queue of expected outputs
    pvec_t m_cur[$];
    bit    m_active;
    exp_t  m_exp[$];
    int    m_pend;
    bit    m_ovf;
    int    m_hs;

    vec_rec_t tbl [22];

    alpha_reverse_buffer #(
        .BITS(BITS), .STATES(STATES), .SYMBOLS(SYMBOLS)
    ) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .block_start(block_start),
        .AlphaMetric(AlphaMetric), .in_ready(in_ready), .out_ready(out_ready),
        .out_valid(out_valid), .out_alpha(out_alpha), .out_index(out_index),
        .out_last(out_last), .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic pvec_t pack_in();
        pvec_t p;
        for (int g = 0; g < STATES; g++) p[g*BITS +: BITS] = AlphaMetric[g];
        return p;
    endfunction

    function automatic pvec_t pack_out();
        pvec_t p;
        for (int g = 0; g < STATES; g++) p[g*BITS +: BITS] = out_alpha[g];
        return p;
    endfunction

    task automatic set_data(input int base);
        for (int g = 0; g < STATES; g++) AlphaMetric[g] = 16'(base * 16 + g);
    endtask

    task automatic set_rand();
        for (int g = 0; g < STATES; g++) AlphaMetric[g] = 16'($urandom);
    endtask

    task automatic model_clear();
        m_cur.delete();
        m_exp.delete();
        m_active = 0;
        m_pend   = 0;
        m_ovf    = 0;
    endtask

    // One clock: drive inputs at negedge, check against model, advance model
    task automatic step(input bit iv, input bit bs, input bit orr);
        bit    exp_rdy;
        exp_t  e;
        pvec_t v;
        in_valid    = iv;
        block_start = bs;
        out_ready   = orr;
        v       = pack_in();
        exp_rdy = (m_pend < 2);
        chk("in_ready", 64'(in_ready), 64'(exp_rdy));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        if (m_pend == 0) chk("idle_valid", 64'(out_valid), 64'd0);
        if (out_valid && orr) begin
            m_hs++;
            if (m_exp.size() == 0) begin
                chk("spurious_out", 64'(out_valid), 64'd0);
            end else begin
                e = m_exp.pop_front();
                chk("out_alpha", 64'(pack_out()), 64'(e.v));
                chk("out_index", 64'(out_index), 64'(e.idx));
                chk("out_last", 64'(out_last), 64'(e.idx == 0));
                if (e.idx == 0) m_pend--;
            end
        end
        if (iv) begin
            if (!exp_rdy) begin
                m_ovf = 1;
            end else if (bs) begin
                m_cur.delete();
                m_cur.push_back(v);
                m_active = 1;
            end else if (m_active) begin
                m_cur.push_back(v);
                if (m_cur.size() == SYMBOLS) begin
                    for (int i = SYMBOLS - 1; i >= 0; i--) begin
                        e.v   = m_cur[i];
                        e.idx = i;
                        m_exp.push_back(e);
                    end
                    m_pend++;
                    m_cur.delete();
                    m_active = 0;
                end
            end else begin
                m_ovf = 1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n     = 0;
        in_valid    = 0;
        block_start = 0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1;
        model_clear();
    endtask

    task automatic write_block(input int base);
        for (int k = 0; k < SYMBOLS; k++) begin
            set_data(base + k);
            step(1, k == 0, 1);
        end
    endtask

    task automatic idle(input int n, input bit orr);
        for (int k = 0; k < n; k++) step(0, 0, orr);
    endtask

    initial begin
        int first, last, nval, hs0, pos;
        bit found;
        clk = 0;
        reset_n = 0;
        in_valid = 0;
        block_start = 0;
        out_ready = 0;
        m_hs = 0;
        set_data(0);
        model_clear();

        // Directed single-block table: write steps 0..9, replay 9..0
        for (int k = 0; k < 22; k++) begin
            tbl[k].iv      = (k < 10);
            tbl[k].bs      = (k == 0);
            tbl[k].orr     = 1;
            tbl[k].base    = k;
            tbl[k].e_valid = (k >= 11 && k <= 20);
            tbl[k].e_idx   = 20 - k;
            tbl[k].e_last  = (k == 20);
        end

        do_reset();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_index", 64'(out_index), 64'd0);
        chk("rst_last", 64'(out_last), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_ready", 64'(in_ready), 64'd1);
        chk("rst_alpha", 64'(pack_out()), 64'd0);

        for (int k = 0; k < 22; k++) begin
            chk("tbl_valid", 64'(out_valid), 64'(tbl[k].e_valid));
            chk("tbl_ovf", 64'(overflow), 64'd0);
            if (tbl[k].e_valid) begin
                chk("tbl_index", 64'(out_index), 64'(tbl[k].e_idx));
                chk("tbl_last", 64'(out_last), 64'(tbl[k].e_last));
                for (int g = 0; g < STATES; g++)
                    chk("tbl_alpha", 64'(out_alpha[g]), 64'(tbl[k].e_idx * 16 + g));
            end
            set_data(tbl[k].base);
            step(tbl[k].iv, tbl[k].bs, tbl[k].orr);
        end

        // Back-to-back blocks: 20 contiguous output cycles, no bubble
        do_reset();
        first = -1; last = -1; nval = 0;
        for (int k = 0; k < 36; k++) begin
            if (out_valid) begin
                if (first < 0) first = k;
                last = k;
                nval++;
            end
            set_data(100 + k);
            step(k < 20, (k == 0) || (k == 10), 1);
        end
        chk("b2b_first", 64'(first), 64'd11);
        chk("b2b_span", 64'(last - first + 1), 64'd20);
        chk("b2b_count", 64'(nval), 64'd20);

        // Backpressure: three blocks with out_ready low, third is dropped
        do_reset();
        for (int k = 0; k < 30; k++) begin
            set_data(k);
            step(1, (k % 10) == 0, 0);
        end
        chk("bp_ready", 64'(in_ready), 64'd0);
        chk("bp_ovf", 64'(overflow), 64'd1);
        chk("bp_hold_valid", 64'(out_valid), 64'd1);
        chk("bp_hold_index", 64'(out_index), 64'd9);
        hs0 = m_hs;
        idle(30, 1);
        chk("bp_hs", 64'(m_hs - hs0), 64'd20);
        chk("bp_drain", 64'(m_exp.size()), 64'd0);

        // Abort and restart: only the second block is replayed
        do_reset();
        hs0 = m_hs;
        for (int k = 0; k < 4; k++) begin
            set_data(50 + k);
            step(1, k == 0, 1);
        end
        write_block(200);
        idle(25, 1);
        chk("abort_hs", 64'(m_hs - hs0), 64'd10);
        chk("abort_ovf", 64'(overflow), 64'd0);
        chk("abort_drain", 64'(m_exp.size()), 64'd0);

        // Stray data with no block_start
        do_reset();
        for (int k = 0; k < 3; k++) begin
            set_data(7 + k);
            step(1, 0, 1);
        end
        idle(4, 1);
        chk("stray_ovf", 64'(overflow), 64'd1);
        chk("stray_valid", 64'(out_valid), 64'd0);
        chk("stray_ready", 64'(in_ready), 64'd1);

        // Reset in the middle of a replay
        do_reset();
        write_block(300);
        found = 0;
        for (int k = 0; k < 30 && !found; k++) begin
            if (out_valid && out_index == 4'd5) found = 1;
            else step(0, 0, 1);
        end
        chk("mid_found", 64'(found), 64'd1);
        do_reset();
        chk("mid_valid", 64'(out_valid), 64'd0);
        chk("mid_ready", 64'(in_ready), 64'd1);
        chk("mid_ovf", 64'(overflow), 64'd0);
        idle(3, 1);
        hs0 = m_hs;
        write_block(400);
        idle(15, 1);
        chk("mid_hs", 64'(m_hs - hs0), 64'd10);

        // Randomized traffic against the model
        do_reset();
        pos = 0;
        for (int k = 0; k < 1500; k++) begin
            bit iv, bs;
            iv = ($urandom_range(0, 9) < 8);
            bs = iv && ((pos == 0 && $urandom_range(0, 49) != 0) || $urandom_range(0, 39) == 0);
            if (iv) begin
                pos = bs ? 1 : pos + 1;
                if (pos == SYMBOLS) pos = 0;
            end
            set_rand();
            step(iv, bs, $urandom_range(0, 3) != 0);
        end
        idle(40, 1);
        chk("rand_drain", 64'(m_exp.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alpha_reverse_buffer.md
Name: alpha_reverse_buffer

Overview:
- Sits directly downstream of the streaming forward (alpha) recursion.
- Captures one alpha vector (STATES metrics) per trellis step for a block of SYMBOLS steps.
- Replays each block in reverse step order (SYMBOLS-1 down to 0), time-aligned with the backward beta/LLR stage.
- Ping-pong double banking lets block k+1 be written while block k is read.

Parameters:
- BITS, 16, width of one state metric.
- STATES, 4, trellis states per alpha vector.
- SYMBOLS, 10, trellis steps per block; must be >= 2.

Ports:
- clk  input  1  clock, rising edge
- reset_n  input  1  synchronous active-low reset
- in_valid  input  1  alpha vector present this cycle
- block_start  input  1  qualifies in_valid; marks step 0 of a new block
- AlphaMetric  input  BITS x STATES (unpacked [STATES])  alpha vector for the current step
- in_ready  output  1  write bank can accept data
- out_ready  input  1  downstream accepts the output vector
- out_valid  output  1  out_alpha holds a valid vector
- out_alpha  output  BITS x STATES (unpacked [STATES])  replayed alpha vector
- out_index  output  $clog2(SYMBOLS)  trellis step of out_alpha
- out_last  output  1  out_alpha is step 0, the final vector of the block
- overflow  output  1  sticky flag: data was dropped

Behaviour:
- Storage and state:
  - Two banks, each SYMBOLS x STATES x BITS.
  - Per bank: full flag.
  - Write side: wr_bank, wr_cnt, wr_active.
  - Read side: rd_bank, rd_cnt, FSM RD_IDLE/RD_RUN.
- Reset (reset_n low at a clock edge):
  - Both full flags cleared; wr_bank=0, rd_bank=0, wr_cnt=0, wr_active=0, FSM=RD_IDLE.
  - out_valid=0, out_alpha all 0, out_index=0, out_last=0, overflow=0.
  - Reset mid-block discards all stored and partial data. No output after reset until a fresh block_start block completes.
- in_ready = !full[wr_bank], combinational.
- Write acceptance: a write occurs when in_valid && in_ready.
  - With block_start=1: store at index 0, wr_cnt<=1, wr_active<=1.
  - Any partial block in wr_bank is abandoned; restart in the same bank, no overflow.
  - With block_start=0 and wr_active=1: store at wr_cnt, wr_cnt++.
  - With block_start=0 and wr_active=0: ignored, overflow<=1.
  - Write that fills index SYMBOLS-1: full[wr_bank]<=1, wr_bank toggles, wr_cnt<=0, wr_active<=0.
- in_valid while in_ready=0: vector dropped, overflow<=1. Overflow is cleared only by reset.
- Read FSM:
  - RD_IDLE: if full[rd_bank] -> load out_alpha from bank[rd_bank][SYMBOLS-1], out_index=SYMBOLS-1, out_valid<=1, rd_cnt<=SYMBOLS-2, go RD_RUN.
  - RD_RUN, out_valid && out_ready, rd_cnt>=0: load bank[rd_bank][rd_cnt], out_index=rd_cnt, out_last=(rd_cnt==0), rd_cnt--.
  - RD_RUN, handshake while out_last=1: full[rd_bank]<=0, rd_bank toggles.
    - If the other bank is already full (before this edge): immediately load its step SYMBOLS-1, no bubble; stay RD_RUN.
    - Otherwise out_valid<=0, go RD_IDLE.
  - out_ready low: out_alpha, out_index, out_last and out_valid hold.
- Latency:
  - Final write of a block sampled at edge N sets full at edge N.
  - Read load at edge N+1; out_valid is high in the cycle after edge N+1.
  - With out_ready held high: SYMBOLS consecutive output cycles per block.
- Simultaneous events:
  - A bank freed by a read-side handshake in the same edge it is needed for writing: in_ready reflects the pre-edge flags. The freed bank becomes writable the next cycle.
  - Write completion and read completion in the same edge are both honoured.
- Throughput: sustained 1 vector/cycle in and out when out_ready=1 continuously.
- All metrics are stored bit-exact; no arithmetic.

Test Plan:
- Single block: SYMBOLS=10, STATES=4, vectors {s*16+g}, block_start on step 0, out_ready=1 -> out_valid 2 cycles after the last write. out_index 9..0, out_alpha[g]=9*16+g first, out_last only on index 0, overflow=0.
- Back-to-back blocks A and B with no gap, out_ready=1 -> B written while A reads; B step 9 follows A step 0 with no bubble. in_ready never drops.
- Backpressure: three blocks input continuously, out_ready=0 -> in_ready falls after block 2 completes. A block 3 vector is dropped and overflow=1. Releasing out_ready replays block 1 then block 2, each reversed, with correct values.
- Abort/restart: block_start at step 0, 4 vectors, then block_start again with a new 10-vector block -> only the new block is replayed. overflow=0.
- Stray data: in_valid without a prior block_start -> nothing stored, overflow=1, out_valid stays 0.
- Reset mid-replay: reset_n low for 1 cycle while out_index=5 -> next cycle out_valid=0, in_ready=1, overflow=0. A following block replays normally.
